// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues word fetches to instruction memory, buffers
// in-order responses in a circular prefetch FIFO, and handles branch/exception redirects.
module fetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        br,
  input  logic [31:0] br_target,
  input  logic        except,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d, outst_q, outst_d, drop_q, drop_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d, out_pc_q, out_pc_d;
  logic [31:0]   target;
  logic [CW:0]   inflight;
  logic          redir, hs, rsp, push, pop;

  assign redir    = br | except;
  assign target   = except ? EXC_VECTOR : (br_target & 32'hFFFF_FFFC);
  assign inflight = {1'b0, cnt_q} + {1'b0, outst_q};

  // Buffered plus in-flight words never exceed DEPTH, so a push always finds room.
  assign imem_req  = ~rst & ~redir & (inflight < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign hs        = imem_req & imem_gnt;

  assign id_valid = ~rst & ~redir & (cnt_q != '0);
  assign id_inst  = mem_q[rd_q];
  assign id_pc    = out_pc_q;
  assign pop      = id_valid & id_ready;

  // A response with nothing outstanding is stray (pre-reset traffic) and is ignored.
  assign rsp  = imem_rvalid & (outst_q != '0);
  assign push = rsp & (drop_q == '0) & ~redir;

  always_comb begin
    outst_d = outst_q;
    if (hs && !rsp)      outst_d = outst_q + CW'(1);
    else if (!hs && rsp) outst_d = outst_q - CW'(1);

    drop_d = (rsp && drop_q != '0) ? drop_q - CW'(1) : drop_q;

    fetch_pc_d = hs   ? fetch_pc_q + 32'd4 : fetch_pc_q;
    out_pc_d   = pop  ? out_pc_q + 32'd4   : out_pc_q;
    wr_d       = push ? wr_q + AW'(1)      : wr_q;
    rd_d       = pop  ? rd_q + AW'(1)      : rd_q;

    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);

    // Everything still in flight after this cycle belongs to the old path; the
    // outstanding count already includes any earlier drops, so it is the new drop count.
    if (redir) begin
      fetch_pc_d = target;
      out_pc_d   = target;
      rd_d       = '0;
      wr_d       = '0;
      cnt_d      = '0;
      drop_d     = outst_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      out_pc_q   <= RESET_PC;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_pc_q   <= out_pc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= imem_rdata;
  end

endmodule
